// File: rtl/fp_cvt_f2i_pipe.sv
// ---------------------------------------------------------------------------
// fp_cvt_f2i_pipe
//
// Three-stage pipelined float-to-integer converter (RISC-V FCVT.W/WU/L/LU).
// It takes raw IEEE binary32/binary64 operands and returns a rounded and
// saturated integer together with {NV,DZ,OF,UF,NX} flags. A sideband tag
// travels with each operation.
//
//   stage 1 : unpack sign / exponent / significand, classify zero/inf/NaN
//   stage 2 : align the significand into 64.3 fixed point (int, G, R, S)
//   stage 3 : round, range check, negate, saturate, flags (output register)
//
// Optional feature: define FP_CVT_F2I_HALF_EN to add binary16 (in_fmt=2).
// Without the macro, in_fmt=2 is treated like the reserved encoding.
//
// Parameters:
//   XLEN   integer result width, 32 or 64 (with 32, L/LU act as W/WU)
//   TAG_W  sideband tag width
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   flush       synchronous drop of every in-flight operation
//   in_valid    operand valid
//   in_ready    converter can accept an operand this cycle
//   in_data     operand (binary32 in [31:0], binary16 in [15:0])
//   in_fmt      0=binary32 1=binary64 2=binary16 3=reserved
//   in_op       0=W 1=WU 2=L 3=LU
//   in_rm       0=RNE 1=RTZ 2=RDN 3=RUP 4=RMM (5..7 behave as RTZ)
//   in_tag      sideband tag, returned unchanged
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   out_result  integer result, 32-bit results sign-extended to XLEN
//   out_flags   {NV,DZ,OF,UF,NX}
//   out_tag     tag belonging to out_result
// ---------------------------------------------------------------------------
module fp_cvt_f2i_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [1:0]       in_fmt,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic s1_valid, s2_valid, s3_valid;
    logic s1_adv, s2_adv, s3_adv;

    // A stage moves on when it is empty or its successor moves on.
    assign s3_adv    = ~s3_valid | out_ready;
    assign s2_adv    = ~s2_valid | s3_adv;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv & ~flush;
    assign out_valid = s3_valid;

    // ------------------------------------------------------------------
    // Stage 1: unpack
    // ------------------------------------------------------------------
    // The significand is kept as a 53-bit value with the binary point
    // after bit 52, so value = sig * 2^(exp-52) for every format.
    logic               u_sign;
    logic signed [12:0] u_exp;
    logic [52:0]        u_sig;
    logic               u_zero, u_inf, u_nan, u_bad;
    logic [1:0]         u_op;

    always_comb begin
        u_sign = 1'b0;
        u_exp  = '0;
        u_sig  = '0;
        u_zero = 1'b0;
        u_inf  = 1'b0;
        u_nan  = 1'b0;
        u_bad  = 1'b0;
        case (in_fmt)
            2'd0: begin
                u_sign = in_data[31];
                // Denormals use exponent 1 with the hidden bit cleared.
                u_exp  = $signed({5'd0, (in_data[30:23] == 8'd0) ? 8'd1 : in_data[30:23]})
                         - 13'sd127;
                u_sig  = {in_data[30:23] != 8'd0, in_data[22:0], 29'd0};
                u_zero = (in_data[30:0] == 31'd0);
                u_inf  = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
                u_nan  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
            end
            2'd1: begin
                u_sign = in_data[63];
                u_exp  = $signed({2'd0, (in_data[62:52] == 11'd0) ? 11'd1 : in_data[62:52]})
                         - 13'sd1023;
                u_sig  = {in_data[62:52] != 11'd0, in_data[51:0]};
                u_zero = (in_data[62:0] == 63'd0);
                u_inf  = (in_data[62:52] == 11'h7FF) && (in_data[51:0] == 52'd0);
                u_nan  = (in_data[62:52] == 11'h7FF) && (in_data[51:0] != 52'd0);
            end
`ifdef FP_CVT_F2I_HALF_EN
            2'd2: begin
                u_sign = in_data[15];
                u_exp  = $signed({8'd0, (in_data[14:10] == 5'd0) ? 5'd1 : in_data[14:10]})
                         - 13'sd15;
                u_sig  = {in_data[14:10] != 5'd0, in_data[9:0], 42'd0};
                u_zero = (in_data[14:0] == 15'd0);
                u_inf  = (in_data[14:10] == 5'h1F) && (in_data[9:0] == 10'd0);
                u_nan  = (in_data[14:10] == 5'h1F) && (in_data[9:0] != 10'd0);
            end
`endif
            default: u_bad = 1'b1;
        endcase
    end

    // With a 32-bit datapath the L/LU variants collapse onto W/WU.
    assign u_op = {in_op[1] & (XLEN == 64), in_op[0]};

    logic               s1_sign;
    logic signed [12:0] s1_exp;
    logic [52:0]        s1_sig;
    logic               s1_zero, s1_inf, s1_nan, s1_bad;
    logic [1:0]         s1_op;
    logic [2:0]         s1_rm;
    logic [TAG_W-1:0]   s1_tag;

    // Stage 1 register: capture the unpacked operand on accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_sig   <= '0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_nan   <= 1'b0;
            s1_bad   <= 1'b0;
            s1_op    <= '0;
            s1_rm    <= '0;
            s1_tag   <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sign <= u_sign;
                s1_exp  <= u_exp;
                s1_sig  <= u_sig;
                s1_zero <= u_zero;
                s1_inf  <= u_inf;
                s1_nan  <= u_nan;
                s1_bad  <= u_bad;
                s1_op   <= u_op;
                s1_rm   <= in_rm;
                s1_tag  <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align to 64.3 fixed point
    // ------------------------------------------------------------------
    // Shifting sig left by (exp+2) gives value * 2^54, so bits [117:54]
    // are the integer part, 53 is G, 52 is R and the rest fold into S.
    logic [6:0]   shamt;
    logic [117:0] aligned;
    logic [63:0]  a_int;
    logic         a_g, a_r, a_s, a_pre_ovf;

    always_comb begin
        shamt     = 7'(s1_exp + 13'sd2);
        aligned   = {65'd0, s1_sig} << shamt;
        a_int     = '0;
        a_g       = 1'b0;
        a_r       = 1'b0;
        a_s       = 1'b0;
        a_pre_ovf = 1'b0;
        if (s1_exp >= 13'sd64) begin
            a_pre_ovf = 1'b1;
        end else if (s1_zero || (s1_exp < -13'sd2)) begin
            a_s = |s1_sig;
        end else begin
            a_int = aligned[117:54];
            a_g   = aligned[53];
            a_r   = aligned[52];
            a_s   = |aligned[51:0];
        end
    end

    logic             s2_sign;
    logic [63:0]      s2_int;
    logic             s2_g, s2_r, s2_s, s2_pre_ovf;
    logic             s2_inf, s2_nan, s2_bad;
    logic [1:0]       s2_op;
    logic [2:0]       s2_rm;
    logic [TAG_W-1:0] s2_tag;

    // Stage 2 register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_int     <= '0;
            s2_g       <= 1'b0;
            s2_r       <= 1'b0;
            s2_s       <= 1'b0;
            s2_pre_ovf <= 1'b0;
            s2_inf     <= 1'b0;
            s2_nan     <= 1'b0;
            s2_bad     <= 1'b0;
            s2_op      <= '0;
            s2_rm      <= '0;
            s2_tag     <= '0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_adv) begin
                s2_sign    <= s1_sign;
                s2_int     <= a_int;
                s2_g       <= a_g;
                s2_r       <= a_r;
                s2_s       <= a_s;
                s2_pre_ovf <= a_pre_ovf;
                s2_inf     <= s1_inf;
                s2_nan     <= s1_nan;
                s2_bad     <= s1_bad;
                s2_op      <= s1_op;
                s2_rm      <= s1_rm;
                s2_tag     <= s1_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round, range check, saturate
    // ------------------------------------------------------------------
    logic        inexact, inc, is_wide, is_uns, ovf, nv;
    logic [64:0] mag, pos_lim, neg_lim;
    logic [63:0] sat_max, sat_min, value, r64, r_res;
    logic [4:0]  r_flags;

    always_comb begin
        inexact = s2_g | s2_r | s2_s;
        case (s2_rm)
            3'd0:    inc = s2_g & (s2_int[0] | s2_r | s2_s);
            3'd2:    inc = s2_sign & inexact;
            3'd3:    inc = ~s2_sign & inexact;
            3'd4:    inc = s2_g;
            default: inc = 1'b0;
        endcase
        // One extra bit so a carry out of 2^64-1 is still seen as overflow.
        mag     = {1'b0, s2_int} + {64'd0, inc};
        is_wide = s2_op[1];
        is_uns  = s2_op[0];

        pos_lim = is_wide ? (is_uns ? 65'h0_FFFF_FFFF_FFFF_FFFF : 65'h0_7FFF_FFFF_FFFF_FFFF)
                          : (is_uns ? 65'h0_0000_0000_FFFF_FFFF : 65'h0_0000_0000_7FFF_FFFF);
        neg_lim = is_wide ? 65'h0_8000_0000_0000_0000 : 65'h0_0000_0000_8000_0000;

        // Unsigned ops reject any negative value that does not round to 0.
        ovf = s2_pre_ovf | s2_inf |
              (s2_sign ? (is_uns ? (mag != 65'd0) : (mag > neg_lim)) : (mag > pos_lim));
        nv  = s2_bad | s2_nan | ovf;

        sat_max = is_uns ? 64'hFFFF_FFFF_FFFF_FFFF
                         : (is_wide ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF);
        sat_min = is_uns ? 64'h0
                         : (is_wide ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000);
        value   = s2_sign ? (64'd0 - mag[63:0]) : mag[63:0];

        if (s2_bad) begin
            r64 = 64'd0;
        end else if (s2_nan || (ovf && !s2_sign)) begin
            r64 = sat_max;
        end else if (ovf) begin
            r64 = sat_min;
        end else begin
            r64 = value;
        end

        // 32-bit results, WU included, are sign-extended from bit 31.
        r_res   = is_wide ? r64 : {{32{r64[31]}}, r64[31:0]};
        r_flags = {nv, 3'b000, inexact & ~nv};
    end

    logic [63:0] s3_result;

    // Output register: holds its contents while the consumer stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s3_valid  <= 1'b0;
            s3_result <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                s3_valid <= 1'b0;
            end else if (s3_adv) begin
                s3_valid <= s2_valid;
            end
            if (s2_valid && s3_adv) begin
                s3_result <= r_res;
                out_flags <= r_flags;
                out_tag   <= s2_tag;
            end
        end
    end

    assign out_result = s3_result[XLEN-1:0];

endmodule

// File: tb/tb_fp_cvt_f2i_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_cvt_f2i_pipe
//
// Self-checking bench for fp_cvt_f2i_pipe (XLEN=64, TAG_W=5). Expected values
// come from directed constants and from ref_model, which converts an operand
// by exact integer/remainder arithmetic. Honours FP_CVT_F2I_HALF_EN.
// ---------------------------------------------------------------------------
module tb_fp_cvt_f2i_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clock     = 1'b0;
    logic             reset     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [63:0]      in_data   = '0;
    logic [1:0]       in_fmt    = '0;
    logic [1:0]       in_op     = '0;
    logic [2:0]       in_rm     = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result;
    logic [4:0]       out_flags;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    fp_cvt_f2i_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_fmt     (in_fmt),
        .in_op      (in_op),
        .in_rm      (in_rm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag)
    );

    always #5 clock = ~clock;

    // Reference conversion: value = m * 2^e2 exactly; truncate, classify
    // the discarded remainder against one half, then round and range-check.
    // Returns {flags[4:0], result[63:0]}.
    function automatic logic [68:0] ref_model(input logic [63:0] d, input logic [1:0] fmt,
                                              input logic [1:0] op, input logic [2:0] rm);
        logic         sgn;
        logic [52:0]  m;
        int           e2, n, sh, cls;
        bit           is_nan, is_inf, is_bad, huge, up, nv, nx, ovf, uns;
        logic [127:0] q, rem, half, r, maxpos, v;
        logic [63:0]  res;
        sgn = 1'b0; m = '0; e2 = 0; sh = 0; cls = 0;
        is_nan = 0; is_inf = 0; is_bad = 0; huge = 0; up = 0; nv = 0; nx = 0; ovf = 0;
        q = '0; rem = '0; half = '0; r = '0; v = '0;
        case (fmt)
            2'd0: begin
                sgn = d[31];
                if (d[30:23] == 8'hFF) begin
                    is_nan = (d[22:0] != 23'd0);
                    is_inf = (d[22:0] == 23'd0);
                end else if (d[30:23] == 8'h00) begin
                    m = 53'(d[22:0]); e2 = -149;
                end else begin
                    m = 53'(d[22:0]) + (53'd1 << 23); e2 = int'(d[30:23]) - 150;
                end
            end
            2'd1: begin
                sgn = d[63];
                if (d[62:52] == 11'h7FF) begin
                    is_nan = (d[51:0] != 52'd0);
                    is_inf = (d[51:0] == 52'd0);
                end else if (d[62:52] == 11'h000) begin
                    m = 53'(d[51:0]); e2 = -1074;
                end else begin
                    m = 53'(d[51:0]) + (53'd1 << 52); e2 = int'(d[62:52]) - 1075;
                end
            end
`ifdef FP_CVT_F2I_HALF_EN
            2'd2: begin
                sgn = d[15];
                if (d[14:10] == 5'h1F) begin
                    is_nan = (d[9:0] != 10'd0);
                    is_inf = (d[9:0] == 10'd0);
                end else if (d[14:10] == 5'h00) begin
                    m = 53'(d[9:0]); e2 = -24;
                end else begin
                    m = 53'(d[9:0]) + (53'd1 << 10); e2 = int'(d[14:10]) - 25;
                end
            end
`endif
            default: is_bad = 1;
        endcase
        n      = (op[1] && XLEN == 64) ? 64 : 32;
        uns    = op[0];
        maxpos = uns ? ((128'd1 << n) - 128'd1) : ((128'd1 << (n - 1)) - 128'd1);
        if (is_bad) begin
            nv = 1; v = '0;
        end else if (is_nan) begin
            nv = 1; v = maxpos;
        end else begin
            if (is_inf || e2 > 70) begin
                huge = 1;
            end else if (e2 >= 0) begin
                q = 128'(m) << e2;
            end else begin
                sh = -e2;
                if (sh > 120) begin
                    q = '0; cls = (m == 53'd0) ? 0 : 1;
                end else begin
                    q    = 128'(m) >> sh;
                    rem  = 128'(m) - (q << sh);
                    half = 128'd1 << (sh - 1);
                    cls  = (rem == 128'd0) ? 0 : (rem < half) ? 1 : (rem == half) ? 2 : 3;
                end
            end
            case (rm)
                3'd0:    up = (cls == 3) || (cls == 2 && q[0]);
                3'd2:    up = sgn && cls != 0;
                3'd3:    up = !sgn && cls != 0;
                3'd4:    up = cls >= 2;
                default: up = 0;
            endcase
            r = q + 128'(up);
            if (huge)     ovf = 1;
            else if (sgn) ovf = uns ? (r != 128'd0) : (r > (128'd1 << (n - 1)));
            else          ovf = (r > maxpos);
            if (ovf) begin
                nv = 1;
                v  = !sgn ? maxpos : (uns ? 128'd0 : (128'd0 - (128'd1 << (n - 1))));
            end else begin
                v  = sgn ? (128'd0 - r) : r;
                nx = (cls != 0);
            end
        end
        res = (n == 32) ? {{32{v[31]}}, v[31:0]} : v[63:0];
        return {nv, 3'b000, nx, res};
    endfunction

    // Random operand biased towards exponents near the integer range,
    // with low mantissa bits sometimes cleared to create ties.
    task automatic rand_operand(output logic [63:0] d, output logic [1:0] fmt,
                                output logic [1:0] op, output logic [2:0] rm);
        logic [63:0] rnd;
        logic [10:0] e11;
        logic [7:0]  e8;
        rnd = {$urandom(), $urandom()};
        rnd = rnd & (64'hFFFF_FFFF_FFFF_FFFF << $urandom_range(0, 52));
        fmt = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        op  = 2'($urandom_range(0, 3));
        rm  = 3'($urandom_range(0, 7));
        e11 = ($urandom_range(0, 19) == 0) ? 11'($urandom()) : 11'(1019 + $urandom_range(0, 72));
        e8  = ($urandom_range(0, 19) == 0) ? 8'($urandom())  : 8'(123 + $urandom_range(0, 40));
        case (fmt)
            2'd1:    d = {rnd[63], e11, rnd[51:0]};
            2'd0:    d = {32'($urandom()), rnd[63], e8, rnd[22:0]};
            default: d = {48'($urandom()), 16'($urandom())};
        endcase
    endtask

    // Push one operation into an empty pipe and wait for its result.
    task automatic run_one(input logic [63:0] d, input logic [1:0] fmt, input logic [1:0] op,
                           input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                           output logic [63:0] res, output logic [4:0] fl,
                           output logic [TAG_W-1:0] otag, output int lat);
        @(negedge clock);
        in_valid = 1'b1; in_data = d; in_fmt = fmt; in_op = op; in_rm = rm; in_tag = tag;
        out_ready = 1'b1;
        lat = -1; res = '0; fl = '0; otag = '0;
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (out_valid) begin
                lat = c; res = out_result; fl = out_flags; otag = out_tag;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
        end
        n_checks++;
        if (out_result !== '0 || out_flags !== 5'd0 || out_tag !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got res=%h fl=%h tag=%h want 0/0/0",
                     out_result, out_flags, out_tag);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready);
        end
    endtask

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  fmt;
        logic [1:0]  op;
        logic [2:0]  rm;
        logic [63:0] res;
        logic [4:0]  fl;
    } vec_t;

    task automatic test_directed();
        vec_t             v [15];
        logic [63:0]      res;
        logic [4:0]       fl;
        logic [TAG_W-1:0] otag;
        int               lat;
        v[0]  = '{64'h40200000,         2'd0, 2'd0, 3'd0, 64'h2,                 5'h01};
        v[1]  = '{64'h40200000,         2'd0, 2'd0, 3'd4, 64'h3,                 5'h01};
        v[2]  = '{64'h40200000,         2'd0, 2'd0, 3'd3, 64'h3,                 5'h01};
        v[3]  = '{64'hBFF8000000000000, 2'd1, 2'd1, 3'd0, 64'h0,                 5'h10};
        v[4]  = '{64'hBFD999999999999A, 2'd1, 2'd1, 3'd0, 64'h0,                 5'h01};
        v[5]  = '{64'h4F000000,         2'd0, 2'd0, 3'd0, 64'h000000007FFFFFFF,  5'h10};
        v[6]  = '{64'h4F000000,         2'd0, 2'd1, 3'd0, 64'hFFFFFFFF80000000,  5'h00};
        v[7]  = '{64'h7FC00000,         2'd0, 2'd3, 3'd0, 64'hFFFFFFFFFFFFFFFF,  5'h10};
        v[8]  = '{64'hC3E0000000000000, 2'd1, 2'd2, 3'd0, 64'h8000000000000000,  5'h00};
        v[9]  = '{64'h43E0000000000000, 2'd1, 2'd2, 3'd0, 64'h7FFFFFFFFFFFFFFF,  5'h10};
        v[10] = '{64'h3FF0000000000000, 2'd3, 2'd0, 3'd0, 64'h0,                 5'h10};
        v[11] = '{64'hFFF0000000000000, 2'd1, 2'd0, 3'd0, 64'hFFFFFFFF80000000,  5'h10};
        v[12] = '{64'h40200000,         2'd0, 2'd0, 3'd6, 64'h2,                 5'h01};
        v[13] = '{64'hC0200000,         2'd0, 2'd0, 3'd2, 64'hFFFFFFFFFFFFFFFD,  5'h01};
        v[14] = '{64'h0000000000000000, 2'd1, 2'd2, 3'd0, 64'h0,                 5'h00};
        for (int i = 0; i < 15; i++) begin
            run_one(v[i].d, v[i].fmt, v[i].op, v[i].rm, TAG_W'(i + 3), res, fl, otag, lat);
            n_checks++;
            if (lat !== 3) begin
                n_fail++; $display("[TB] FAIL dir%0d_latency got %0d want 3", i, lat);
            end
            n_checks++;
            if (res !== v[i].res || fl !== v[i].fl) begin
                n_fail++;
                $display("[TB] FAIL dir%0d_result got %h/%h want %h/%h", i, res, fl, v[i].res, v[i].fl);
            end
            n_checks++;
            if (otag !== TAG_W'(i + 3)) begin
                n_fail++; $display("[TB] FAIL dir%0d_tag got %0d want %0d", i, otag, i + 3);
            end
        end
    endtask

    task automatic test_half();
        logic [63:0]      res;
        logic [4:0]       fl;
        logic [TAG_W-1:0] otag;
        int               lat;
        logic [63:0]      want_res;
        logic [4:0]       want_fl;
`ifdef FP_CVT_F2I_HALF_EN
        want_res = 64'h2; want_fl = 5'h01;
`else
        want_res = 64'h0; want_fl = 5'h10;
`endif
        run_one(64'h3E00, 2'd2, 2'd0, 3'd0, 5'd9, res, fl, otag, lat);
        n_checks++;
        if (res !== want_res || fl !== want_fl) begin
            n_fail++;
            $display("[TB] FAIL half_1p5 got %h/%h want %h/%h", res, fl, want_res, want_fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [68:0]      exp_q [$];
        logic [TAG_W-1:0] tag_q [$];
        logic [63:0]      ops   [8];
        logic [68:0]      e;
        logic [TAG_W-1:0] et;
        logic [63:0]      held_res;
        logic [TAG_W-1:0] held_tag;
        bit               held, saw_stall;
        int               sent, got, cyc;
        held = 0; saw_stall = 0; sent = 0; got = 0; cyc = 0;
        held_res = '0; held_tag = '0;
        for (int i = 0; i < 8; i++) ops[i] = 64'h4000000000000000 + (64'(i) << 49);
        while (got < 8 && cyc < 40) begin
            @(negedge clock);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_data = ops[sent]; in_fmt = 2'd1; in_op = 2'd2; in_rm = 3'(sent % 5);
                in_tag  = TAG_W'(sent);
            end
            #1;
            if (held) begin
                n_checks++;
                if (out_result !== held_res || out_tag !== held_tag || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_hold got %h/%0d want %h/%0d", out_result, out_tag,
                             held_res, held_tag);
                end
            end
            held = out_valid && !out_ready;
            held_res = out_result; held_tag = out_tag;
            if (in_valid && !in_ready) saw_stall = 1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data, in_fmt, in_op, in_rm));
                tag_q.push_back(in_tag);
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL b2b_extra got tag %0d want none", out_tag);
                end else begin
                    e = exp_q.pop_front(); et = tag_q.pop_front();
                    if (out_result !== e[63:0] || out_flags !== e[68:64] || out_tag !== et) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_result got %h/%h/%0d want %h/%h/%0d", out_result,
                                 out_flags, out_tag, e[63:0], e[68:64], et);
                    end
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got !== 8) begin
            n_fail++; $display("[TB] FAIL b2b_count got %0d want 8", got);
        end
        n_checks++;
        if (saw_stall !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_in_ready_drop got %0b want 1", saw_stall);
        end
    endtask

    task automatic test_random();
        localparam int N = 600;
        logic [68:0]      exp_q [$];
        logic [TAG_W-1:0] tag_q [$];
        logic [68:0]      e;
        logic [TAG_W-1:0] et;
        logic [63:0]      d;
        logic [1:0]       fmt, op;
        logic [2:0]       rm;
        int               sent, got, cyc, bad;
        bit               accepted;
        sent = 0; got = 0; cyc = 0; bad = 0; accepted = 0;
        while ((sent < N || got < N) && cyc < 20000) begin
            @(negedge clock);
            if (accepted) in_valid = 1'b0;
            accepted = 0;
            if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                rand_operand(d, fmt, op, rm);
                in_valid = 1'b1; in_data = d; in_fmt = fmt; in_op = op; in_rm = rm;
                in_tag = TAG_W'(sent);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data, in_fmt, in_op, in_rm));
                tag_q.push_back(in_tag);
                sent++;
                accepted = 1;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL rand_extra got tag %0d want none", out_tag);
                end else begin
                    e = exp_q.pop_front(); et = tag_q.pop_front();
                    if (out_result !== e[63:0] || out_flags !== e[68:64] || out_tag !== et) begin
                        n_fail++;
                        if (bad < 10)
                            $display("[TB] FAIL rand_result got %h/%h/%0d want %h/%h/%0d",
                                     out_result, out_flags, out_tag, e[63:0], e[68:64], et);
                        bad++;
                    end
                end
                got++;
            end
            cyc++;
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got !== N) begin
            n_fail++; $display("[TB] FAIL rand_count got %0d want %0d", got, N);
        end
    endtask

    task automatic test_flush();
        logic [63:0]      res;
        logic [4:0]       fl;
        logic [TAG_W-1:0] otag;
        int               lat, seen;
        seen = 0;
        @(negedge clock);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h40200000; in_fmt = 2'd0; in_op = 2'd0; in_rm = 3'd0;
        in_tag = 5'd21;
        @(negedge clock);
        in_tag = 5'd22;
        @(negedge clock);
        flush = 1'b1; in_tag = 5'd23;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_in_ready got %0b want 0", in_ready);
        end
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clock);
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("[TB] FAIL flush_drop got %0d results want 0", seen);
        end
        run_one(64'hC0200000, 2'd0, 2'd2, 3'd1, 5'd24, res, fl, otag, lat);
        n_checks++;
        if (res !== 64'hFFFFFFFFFFFFFFFE || fl !== 5'h01 || otag !== 5'd24) begin
            n_fail++;
            $display("[TB] FAIL flush_recover got %h/%h/%0d want fffffffffffffffe/01/24",
                     res, fl, otag);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        @(negedge clock);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h3FF8000000000000; in_fmt = 2'd1; in_op = 2'd2; in_rm = 3'd0;
        in_tag = 5'd30;
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_state got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clock);
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("[TB] FAIL midreset_drop got %0d results want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_half();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_cvt_f2i_pipe.md
Name: fp_cvt_f2i_pipe

Overview:
- Pipelined, parametrised float-to-integer converter with a valid/ready handshake, replacing the single-cycle combinational f2i path.
- Accepts raw IEEE binary32/binary64 operands and produces RISC-V-compliant W/WU/L/LU results with correct rounding for all five modes.
- Sits between the FPU issue stage and integer writeback.
- Fixed 3-stage latency; an opaque tag travels with each operation for writeback steering.

Parameters:
- XLEN, 64, integer result width; 32 or 64. With 32, op[1] is ignored (L/LU behave as W/WU).
- TAG_W, 5, width of the sideband tag carried alongside each operation.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all in-flight operations.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept an operand this cycle.
- in_data  in  64  operand; binary32 uses [31:0], upper bits ignored.
- in_fmt  in  2  0=binary32, 1=binary64, 2=binary16 (optional feature only), 3=reserved.
- in_op  in  2  0=W (s32), 1=WU (u32), 2=L (s64), 3=LU (u64).
- in_rm  in  3  0=RNE, 1=RTZ, 2=RDN, 3=RUP, 4=RMM.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  integer result; 32-bit ops are sign-extended to XLEN.
- out_flags  out  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF are always 0.
- out_tag  out  TAG_W  tag of the current result.

Behaviour:
- Reset (reset=0, async): all stage valid bits clear; out_valid=0, out_result=0, out_flags=0, out_tag=0. Consequently in_ready=1 after reset release. An operation in flight when reset asserts is lost and no result is produced.
- Stage 1: unpack sign, exponent and significand (hidden bit restored; denormals use exponent 1 with hidden bit 0); classify zero, inf, NaN.
- Stage 2: align the significand into a 64.3 fixed-point form (integer part plus G, R and sticky S). Exponent ≥ 64 sets a pre-overflow bit. Exponent < -2 gives integer part 0, G=R=0, S=(significand≠0).
- Stage 3: round, negate, saturate, compute flags; registered output.
- Rounding increment, with inexact=G|R|S:
  - RNE: G&(LSB|R|S)
  - RTZ: 0
  - RDN: sign&inexact
  - RUP: ~sign&inexact
  - RMM: G
  - rm 5–7: treated as RTZ, no flag.
- Range check uses the rounded magnitude M:
  - W: M>2^31-1 if positive; M>2^31 if negative.
  - WU: any negative with M≠0; M>2^32-1.
  - L: same as W with 2^63.
  - LU: same as WU with 2^64.
  - Negative values rounding to magnitude 0 are legal for unsigned ops: result 0, NX only.
- Invalid result (NV=1, NX=0):
  - NaN or positive overflow/+inf → max (signed 2^(n-1)-1, unsigned all-ones).
  - Negative overflow/-inf → signed min, unsigned 0.
- NX=1 iff inexact and not NV.
- 32-bit results are sign-extended to XLEN, including WU (0xFFFFFFFF → all-ones).
- Handshake:
  - A stage advances when it is empty or its successor advances. The output stage advances when ~out_valid | out_ready.
  - in_ready = ~s1_valid | s1_advance. Accept occurs on in_valid&in_ready.
  - out_* remain stable while out_valid&~out_ready.
  - Full throughput: one result per cycle when unstalled.
  - Latency: 3 cycles from accept to out_valid.
- Flush: clears all valid bits next edge; in_valid during the flush cycle is not accepted (in_ready=0 while flush=1).
- in_fmt=3: result 0, NV=1.

Optional Feature:
- Macro FP_CVT_F2I_HALF_EN.
- Defined: in_fmt=2 converts binary16 in in_data[15:0] (bias 15) using the identical rounding and range rules.
- Undefined: in_fmt=2 is handled as reserved (result 0, NV=1) and no binary16 unpack logic is synthesised.

Test Plan:
- 0x40200000 (2.5f), W, RNE → 0x0000000000000002, flags 0x01. Same with RMM → 0x3, flags 0x01. Same with RUP → 0x3, flags 0x01.
- 0xBFF8000000000000 (-1.5d), WU, RNE → 0, flags 0x10. 0xBFD999999999999A (-0.4d), WU, RNE → 0, flags 0x01.
- 0x4F000000 (2^31 f), W → 0x000000007FFFFFFF, NV. Same operand with WU → 0xFFFFFFFF80000000, flags 0. 0x7FC00000 (qNaN), LU → 0xFFFFFFFFFFFFFFFF, NV.
- 0xC3E0000000000000 (-2^63 d), L → 0x8000000000000000, flags 0. 0x43E0000000000000 (+2^63 d), L → 0x7FFFFFFFFFFFFFFF, NV.
- Back-to-back stream of 8 operands with out_ready held low cycles 4–6 → no loss or duplication; in_ready drops when the pipe is full; results and tags appear in order. A reset pulse in cycle 2 of a further op → out_valid=0 and no result emitted.
- With FP_CVT_F2I_HALF_EN, 0x3E00 (1.5h), W, RNE → 0x2, NX. Without the macro, same stimulus → 0, NV.
